framebuffer_bank_scheduler: RTL
===============================

// Module: framebuffer_bank_scheduler
// PURPOSE
//  Double-buffer scheduler for the framebuffer multimem. The writer (control_module, port A) always
//  fills the back bank; the reader (framebuffer_fetch, port B) always scans the front bank.
//  Swaps the banks only at a display frame boundary after the writer reports a complete frame,
//  so the display never shows a torn image. It stalls the writer until the swap and guard period finish.
// PARAMETERS
//  WR_ADDR_WIDTH   12  port-A address width per bank, in bytes
//  RD_ADDR_WIDTH   11  port-B address width per bank, in 16-bit words
//  GUARD_CYCLES    4   post-swap cycles with wr_stall held, to drain the fetch prefetch; 0 = no guard
//  GUARD_WIDTH     3   counter width for GUARD_CYCLES
// PORTS
//  clk_in          in   1   clk_root domain clock
//  reset           in   1   asynchronous, active-high
//  wr_frame_done   in   1   1-cycle pulse: writer has written the last byte of a frame
//  wr_busy         in   1   writer is mid-transaction (port A write in progress)
//  rd_frame_end    in   1   1-cycle pulse: scanner finished the last row of the frame
//  force_swap      in   1   1-cycle pulse from a debug command: swap at the next cycle, ignoring frame end
//  wr_addr_in      in   WR_ADDR_WIDTH   writer's in-bank address
//  rd_addr_in      in   RD_ADDR_WIDTH   fetch's in-bank address
//  wr_addr_out     out  WR_ADDR_WIDTH+1 {write_bank, wr_addr_in}, combinational
//  rd_addr_out     out  RD_ADDR_WIDTH+1 {read_bank, rd_addr_in}, combinational
//  write_bank      out  1   registered
//  read_bank       out  1   registered; always equals ~write_bank
//  swap_pending    out  1   a completed frame is waiting for a boundary
//  wr_stall        out  1   writer must not start new writes
//  swap_count      out  8   swaps performed; wraps modulo 256
//  frames_dropped  out  8   frames overwritten before being shown; saturates at 255
// BEHAVIOUR
//  Reset values: write_bank=1, read_bank=0, swap_pending=0, wr_stall=0, both counters=0, state=IDLE.
//  FSM states: IDLE, PENDING, SWAP, GUARD. All outputs are registered except the address concatenations.
//  IDLE: wr_stall=0.
//   - wr_frame_done & rd_frame_end & !wr_busy in the same cycle -> SWAP.
//   - otherwise wr_frame_done -> PENDING.
//   - force_swap -> SWAP.
//  PENDING: swap_pending=1, wr_stall=1.
//   - (rd_frame_end | force_swap) & !wr_busy -> SWAP.
//   - rd_frame_end while wr_busy=1 -> stay; wait for the next frame end.
//   - a further wr_frame_done -> frames_dropped++ (saturating); stay in PENDING.
//  SWAP (exactly 1 cycle): toggle write_bank and read_bank together; swap_count++; swap_pending<=0.
//   - GUARD_CYCLES==0 -> IDLE; else -> GUARD.
//  GUARD: wr_stall=1; count 0..GUARD_CYCLES-1, then -> IDLE.
//   - wr_frame_done in GUARD -> frames_dropped++.
//   - force_swap in GUARD is ignored.
//  Latency: a frame-end pulse in PENDING moves bank bits one clock later. wr_stall rises the clock after wr_frame_done.
//  Invariant: write_bank != read_bank in every cycle, including during reset.
//  Reset mid-operation: FSM returns to IDLE and bank bits return to their reset values. Any pending frame is discarded, not counted.
//  force_swap in IDLE with no complete frame is allowed; this is debug only and may show a partial frame.
// STRUCTURE
//  Shared header fb_sched_defs.vh: FSM state localparams (2-bit), bank reset constants, counter widths.
//  Sub-module: the existing timeout module, reused as the GUARD counter (value=GUARD_CYCLES-1).
//  Everything else stays inline: FSM, the two counters, address muxing.
//  Integration in main: wr_addr_out and rd_addr_out feed multimem AddressA and AddressB, which widen by one bit.
// TESTING
//  1. Reset -> write_bank=1, read_bank=0, wr_stall=0, swap_count=0, frames_dropped=0.
//  2. wr_frame_done, then rd_frame_end 50 cycles later with wr_busy=0 -> swap_pending high for 50 cycles;
//     banks flip 1 clock after rd_frame_end; swap_count=1; wr_stall high for 1+4 cycles after the swap.
//  3. wr_frame_done and rd_frame_end in the same cycle -> banks flip the next cycle; PENDING is never entered.
//  4. PENDING, rd_frame_end while wr_busy=1 -> no swap; the next rd_frame_end with wr_busy=0 -> swap.
//  5. Three wr_frame_done pulses before any frame end -> frames_dropped=2.
//     Drive 300 drops -> frames_dropped=255.
//  6. Assert reset during GUARD -> immediate IDLE with reset values.
//     force_swap in IDLE -> one swap, swap_count increments.

Source files
------------

// File: rtl/framebuffer_bank_scheduler_pkg.sv
// Shared types and constants for the framebuffer double-buffer scheduler.
package framebuffer_bank_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2,
    ST_GUARD   = 2'd3
  } sched_state_t;

  localparam logic WRITE_BANK_RESET = 1'b1;
  localparam logic READ_BANK_RESET  = 1'b0;
  localparam int   COUNT_WIDTH      = 8;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/framebuffer_bank_scheduler_timeout.sv
// Generic cycle timeout: counts while enabled, flags expiry when the count reaches value.
// Dropping enable clears the count, so each enable window restarts from zero.
module framebuffer_bank_scheduler_timeout #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  assign expired = enable && (count == value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/framebuffer_bank_scheduler.sv
// Double-buffer bank scheduler: writer fills the back bank, scanner reads the front bank,
// banks swap only on a display frame boundary after a completed frame, then a stall guard drains prefetch.
module framebuffer_bank_scheduler
  import framebuffer_bank_scheduler_pkg::*;
#(
  parameter int WR_ADDR_WIDTH = 12,
  parameter int RD_ADDR_WIDTH = 11,
  parameter int GUARD_CYCLES  = 4,
  parameter int GUARD_WIDTH   = 3
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     wr_frame_done,
  input  logic                     wr_busy,
  input  logic                     rd_frame_end,
  input  logic                     force_swap,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [RD_ADDR_WIDTH-1:0] rd_addr_in,
  output logic [WR_ADDR_WIDTH:0]   wr_addr_out,
  output logic [RD_ADDR_WIDTH:0]   rd_addr_out,
  output logic                     write_bank,
  output logic                     read_bank,
  output logic                     swap_pending,
  output logic                     wr_stall,
  output logic [COUNT_WIDTH-1:0]   swap_count,
  output logic [COUNT_WIDTH-1:0]   frames_dropped
);

  localparam logic [GUARD_WIDTH-1:0] GUARD_LAST =
    (GUARD_CYCLES > 0) ? GUARD_WIDTH'(GUARD_CYCLES - 1) : '0;

  sched_state_t state;
  logic         swap_go;
  logic         drop_frame;
  logic         guard_done;

  assign wr_addr_out = {write_bank, wr_addr_in};
  assign rd_addr_out = {read_bank, rd_addr_in};

  // In IDLE a completed frame takes precedence over a debug force unless it can swap immediately.
  assign swap_go =
    ((state == ST_IDLE) &&
     ((wr_frame_done && rd_frame_end && !wr_busy) || (!wr_frame_done && force_swap))) ||
    ((state == ST_PENDING) && (rd_frame_end || force_swap) && !wr_busy);

  // Any frame completed while one is already waiting or being swapped in never reaches the display.
  assign drop_frame = wr_frame_done && (state != ST_IDLE);

  framebuffer_bank_scheduler_timeout #(
    .WIDTH (GUARD_WIDTH)
  ) u_guard (
    .clk     (clk_in),
    .rst     (reset),
    .enable  (state == ST_GUARD),
    .value   (GUARD_LAST),
    .expired (guard_done)
  );

  // Outputs are registered alongside the state so the bank bits change on the edge entering SWAP.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      write_bank     <= WRITE_BANK_RESET;
      read_bank      <= READ_BANK_RESET;
      swap_pending   <= 1'b0;
      wr_stall       <= 1'b0;
      swap_count     <= '0;
      frames_dropped <= '0;
    end else begin
      if (drop_frame) begin
        frames_dropped <= sat_inc(frames_dropped);
      end

      if (swap_go) begin
        state        <= ST_SWAP;
        write_bank   <= ~write_bank;
        read_bank    <= ~read_bank;
        swap_count   <= swap_count + 1'b1;
        swap_pending <= 1'b0;
        wr_stall     <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (wr_frame_done) begin
              state        <= ST_PENDING;
              swap_pending <= 1'b1;
              wr_stall     <= 1'b1;
            end
          end
          ST_PENDING: begin
            state <= ST_PENDING;
          end
          ST_SWAP: begin
            if (GUARD_CYCLES == 0) begin
              state    <= ST_IDLE;
              wr_stall <= 1'b0;
            end else begin
              state <= ST_GUARD;
            end
          end
          ST_GUARD: begin
            if (guard_done) begin
              state    <= ST_IDLE;
              wr_stall <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
